// File: rtl/divider_8bit.sv
// 8-bit unsigned restoring divider: one quotient bit per clock, MSB first,
// registered results that change only when an operation completes.
module divider_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       strt,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       not_valid,
  output logic       idle
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  state_e     state_q, state_d;

  logic [7:0] dvd_q, dvd_d;   // dividend bits shifted out, quotient bits shifted in
  logic [7:0] dvs_q, dvs_d;
  logic [7:0] rem_q, rem_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quo_q, quo_d;
  logic [7:0] remo_q, remo_d;
  logic       nv_q, nv_d;
  logic       idle_q, idle_d;

  logic       accept;
  logic       div_zero;
  logic       last_step;
  logic [8:0] part_rem;
  logic [7:0] diff;
  logic       qbit;

  always_comb begin
    accept    = (state_q == IDLE) && strt;
    div_zero  = (dvs_q == '0);
    last_step = div_zero || (cnt_q == 3'd7);
    // Trial value needs the 9th bit; once the subtraction succeeds the
    // difference is below the divisor, so 8 bits hold it.
    part_rem  = {rem_q, dvd_q[7]};
    qbit      = (part_rem >= {1'b0, dvs_q});
    diff      = part_rem[7:0] - dvs_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (strt)      state_d = CALC;
      CALC: if (last_step) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    remo_d = remo_q;
    nv_d   = nv_q;
    idle_d = (state_d == IDLE);

    if (accept) begin
      dvd_d = dividend;
      dvs_d = divisor;
      rem_d = '0;
      cnt_d = '0;
    end else if (state_q == CALC) begin
      if (div_zero) begin
        quo_d  = '1;
        remo_d = dvd_q;
        nv_d   = 1'b1;
      end else begin
        rem_d = qbit ? diff : part_rem[7:0];
        dvd_d = {dvd_q[6:0], qbit};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          quo_d  = {dvd_q[6:0], qbit};
          remo_d = qbit ? diff : part_rem[7:0];
          nv_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      remo_q <= '0;
      nv_q   <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      remo_q <= remo_d;
      nv_q   <= nv_d;
      idle_q <= idle_d;
    end
  end

  // Output logic
  always_comb begin
    quotient  = quo_q;
    remainder = remo_q;
    not_valid = nv_q;
    idle      = idle_q;
  end

endmodule

// File: tb/tb_divider_8bit.sv
// Directed table, hand-written corner sequences and a random sweep for divider_8bit.
module tb_divider_8bit;

  logic       clk = 1'b0;
  logic       rst, strt;
  logic [7:0] dividend, divisor;
  logic [7:0] quotient, remainder;
  logic       not_valid, idle;

  int n_pass = 0;
  int n_total = 0;

  divider_8bit dut (
    .clk(clk), .rst(rst), .strt(strt), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .not_valid(not_valid), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] r;
    logic       nv;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Issue a one-cycle start and count edges until idle returns high.
  task automatic do_op(input logic [7:0] dd, input logic [7:0] dv, output int lat);
    @(negedge clk);
    dividend = dd; divisor = dv; strt = 1'b1;
    @(posedge clk); #1;
    strt = 1'b0;
    lat = 0;
    while (!idle && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; strt = 1'b0; dividend = '0; divisor = '0;

    vecs[0]  = '{8'd25,  8'd5,   8'd5,   8'd0,   1'b0, 8};
    vecs[1]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8};
    vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8};
    vecs[3]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
    vecs[4]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
    vecs[5]  = '{8'd77,  8'd0,   8'd255, 8'd77,  1'b1, 1};
    vecs[6]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 8};
    vecs[7]  = '{8'd0,   8'd7,   8'd0,   8'd0,   1'b0, 8};
    vecs[8]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 8};
    vecs[9]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 8};
    vecs[10] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1, 1};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_idle", idle, 1);
    chk("reset_q", quotient, 0);
    chk("reset_r", remainder, 0);
    chk("reset_nv", not_valid, 0);

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].dd, vecs[i].dv, lat);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_q", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d_r", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d_nv", i), not_valid, vecs[i].nv);
    end

    // not_valid stays set while a new operation runs after a divide-by-zero
    do_op(8'd40, 8'd0, lat);
    @(negedge clk);
    dividend = 8'd9; divisor = 8'd3; strt = 1'b1;
    @(posedge clk); #1;
    strt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("nv_hold_busy_idle", idle, 0);
    chk("nv_hold_busy_nv", not_valid, 1);
    chk("nv_hold_busy_q", quotient, 255);
    chk("nv_hold_busy_r", remainder, 40);
    repeat (5) @(posedge clk);
    #1;
    chk("nv_hold_done_idle", idle, 1);
    chk("nv_hold_done_nv", not_valid, 0);
    chk("nv_hold_done_q", quotient, 3);

    // Reset mid-operation aborts without a later result
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd3; strt = 1'b1;
    @(posedge clk); #1;
    strt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_idle", idle, 1);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_nv", not_valid, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_later_q", quotient, 0);
    chk("abort_later_r", remainder, 0);
    chk("abort_later_idle", idle, 1);

    // Start held high through an operation with changing operands
    @(negedge clk);
    dividend = 8'd50; divisor = 8'd6; strt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 8'd90; divisor = 8'd9;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      chk($sformatf("busy_idle_e%0d", e), idle, 0);
    end
    chk("busy_no_partial_q", quotient, 0);
    @(posedge clk); #1;
    chk("busy_done_idle", idle, 1);
    chk("busy_done_q", quotient, 8);
    chk("busy_done_r", remainder, 2);
    @(posedge clk); #1;
    strt = 1'b0;
    chk("restart_idle", idle, 0);
    lat = 0;
    while (!idle && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("restart_lat", lat, 8);
    chk("restart_q", quotient, 10);
    chk("restart_r", remainder, 0);

    // Random sweep against the division identity and latency
    for (int k = 0; k < 300; k++) begin
      logic [7:0] a, b;
      int exp_lat;
      a = 8'($urandom_range(0, 255));
      b = (k % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      exp_lat = (b == 0) ? 1 : 8;
      do_op(a, b, lat);
      chk($sformatf("sweep%0d_lat", k), lat, exp_lat);
      if (b == 0) begin
        chk($sformatf("sweep%0d_dz", k),
            {not_valid, quotient, remainder}, {1'b1, 8'hFF, a});
      end else begin
        chk($sformatf("sweep%0d_q", k), quotient, int'(a) / int'(b));
        chk($sformatf("sweep%0d_ident", k),
            int'(quotient) * int'(b) + int'(remainder), int'(a));
        chk($sformatf("sweep%0d_rlt", k), int'(remainder < b), 1);
        chk($sformatf("sweep%0d_nv", k), not_valid, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
